// File: rtl/blft_row_stream.sv
// blft_row_stream: 3-tap edge-preserving horizontal filter over a raster pixel stream.
// Latency: output strobes 2 cycles after the transfer that completes its window; row-end flush output 1 cycle later.
// Backpressure: in_ready_o drops for exactly one cycle after each end-of-row pixel while that column is flushed.
module blft_row_stream #(
  parameter int DATA_W  = 9,
  parameter int ADDR_W  = 16,
  parameter int IMG_W   = 256,
  parameter int NUM_PIX = 65536
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [DATA_W-1:0] t_near_i,
  input  logic [DATA_W-1:0] t_far_i,
  input  logic              bypass_i,
  output logic              out_valid_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              finish_o,
  output logic              addr_err_o
);
  // Column index width, pixel counter width (one extra bit so a full
  // 2**ADDR_W frame is representable), and weighted-sum width (sum <= 8*max).
  localparam int CW = $clog2(IMG_W);
  localparam int EW = ADDR_W + 1;
  localparam int SW = DATA_W + 3;
  localparam logic [EW-1:0]     NUM_PIX_E = EW'(NUM_PIX);
  localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);

  // Front end: pixel counter, two-pixel history, flush flag, status flags
  logic [EW-1:0]     exp_q, exp_d;
  logic [DATA_W-1:0] pl_q, pl_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              flush_q, flush_d;
  logic              err_q, err_d;
  logic              finish_q, finish_d;

  // Stage 1: assembled window
  logic              s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0] s1_pl_q, s1_pl_d;
  logic [DATA_W-1:0] s1_pc_q, s1_pc_d;
  logic [DATA_W-1:0] s1_pr_q, s1_pr_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;

  // Stage 2: weighted sum and divisor
  logic              s2_vld_q;
  logic [SW-1:0]     s2_sum_q, s2_sum_d;
  logic [3:0]        s2_w_q, s2_w_d;
  logic [DATA_W-1:0] s2_pc_q;
  logic              s2_byp_q;
  logic [ADDR_W-1:0] s2_addr_q;

  // Stage 3: registered outputs
  logic              out_vld_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_dat_q, out_dat_d;

  logic              xfer;
  logic              restart;
  logic [EW-1:0]     exp_eff;
  logic [CW-1:0]     col;
  logic [DATA_W-1:0] dl, dr;
  logic [1:0]        wl, wr;

  // The flush cycle is the only time input is refused.
  assign in_ready_o = ~flush_q;
  assign xfer       = in_valid_i & ~flush_q;
  // Address 0 after a complete frame starts a new frame instead of being an error.
  assign restart    = xfer && (in_addr_i == '0) && (exp_q >= NUM_PIX_E);
  assign exp_eff    = restart ? '0 : exp_q;
  assign col        = exp_eff[CW-1:0];

  // Accept a pixel or flush the row end: build the window for the column now complete.
  always_comb begin
    exp_d     = exp_q;
    pl_d      = pl_q;
    pc_d      = pc_q;
    flush_d   = 1'b0;
    err_d     = err_q;
    finish_d  = finish_q;
    s1_vld_d  = 1'b0;
    s1_pl_d   = pl_q;
    s1_pc_d   = pc_q;
    s1_pr_d   = pc_q;
    s1_addr_d = exp_q[ADDR_W-1:0] - ADDR_W'(1);
    if (flush_q) begin
      // Last column of the row: right neighbour replicates the centre.
      s1_vld_d = 1'b1;
    end else if (xfer) begin
      exp_d   = exp_eff + EW'(1);
      pl_d    = pc_q;
      pc_d    = in_data_i;
      flush_d = (col == COL_LAST);
      if ({1'b0, in_addr_i} != exp_eff) begin
        err_d = 1'b1;
      end
      if (col != '0) begin
        s1_vld_d = 1'b1;
        s1_pr_d  = in_data_i;
        // Emitting column 0: left neighbour replicates the centre.
        if (col == CW'(1)) begin
          s1_pl_d = pc_q;
        end
      end
    end
    if (restart) begin
      finish_d = 1'b0;
    end else if (out_vld_q && (out_addr_q == LAST_ADDR)) begin
      finish_d = 1'b1;
    end
  end

  // Range weights and weighted sum for the window held in stage 1.
  always_comb begin
    dl       = (s1_pl_q > s1_pc_q) ? (s1_pl_q - s1_pc_q) : (s1_pc_q - s1_pl_q);
    dr       = (s1_pr_q > s1_pc_q) ? (s1_pr_q - s1_pc_q) : (s1_pc_q - s1_pr_q);
    wl       = (dl <= t_near_i) ? 2'd2 : ((dl <= t_far_i) ? 2'd1 : 2'd0);
    wr       = (dr <= t_near_i) ? 2'd2 : ((dr <= t_far_i) ? 2'd1 : 2'd0);
    s2_sum_d = (SW'(s1_pc_q) << 2) + (SW'(wl) * SW'(s1_pl_q)) + (SW'(wr) * SW'(s1_pr_q));
    s2_w_d   = 4'd4 + {2'b00, wl} + {2'b00, wr};
  end

  // Rounded division by the total weight (4..8), or pass-through in bypass.
  always_comb begin
    out_dat_d = '0;
    case (s2_w_q)
      4'd4:    out_dat_d = DATA_W'((s2_sum_q + SW'(2)) >> 2);
      4'd5:    out_dat_d = DATA_W'((s2_sum_q + SW'(2)) / SW'(5));
      4'd6:    out_dat_d = DATA_W'((s2_sum_q + SW'(3)) / SW'(6));
      4'd7:    out_dat_d = DATA_W'((s2_sum_q + SW'(3)) / SW'(7));
      default: out_dat_d = DATA_W'((s2_sum_q + SW'(4)) >> 3);
    endcase
    if (s2_byp_q) begin
      out_dat_d = s2_pc_q;
    end
  end

  // Front-end and stage-1 registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q     <= '0;
      pl_q      <= '0;
      pc_q      <= '0;
      flush_q   <= 1'b0;
      err_q     <= 1'b0;
      finish_q  <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_pl_q   <= '0;
      s1_pc_q   <= '0;
      s1_pr_q   <= '0;
      s1_addr_q <= '0;
    end else begin
      exp_q     <= exp_d;
      pl_q      <= pl_d;
      pc_q      <= pc_d;
      flush_q   <= flush_d;
      err_q     <= err_d;
      finish_q  <= finish_d;
      s1_vld_q  <= s1_vld_d;
      s1_pl_q   <= s1_pl_d;
      s1_pc_q   <= s1_pc_d;
      s1_pr_q   <= s1_pr_d;
      s1_addr_q <= s1_addr_d;
    end
  end

  // Stage-2 and output registers; output data/address only move on a strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_vld_q   <= 1'b0;
      s2_sum_q   <= '0;
      s2_w_q     <= 4'd4;
      s2_pc_q    <= '0;
      s2_byp_q   <= 1'b0;
      s2_addr_q  <= '0;
      out_vld_q  <= 1'b0;
      out_addr_q <= '0;
      out_dat_q  <= '0;
    end else begin
      s2_vld_q  <= s1_vld_q;
      s2_sum_q  <= s2_sum_d;
      s2_w_q    <= s2_w_d;
      s2_pc_q   <= s1_pc_q;
      s2_byp_q  <= bypass_i;
      s2_addr_q <= s1_addr_q;
      out_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        out_addr_q <= s2_addr_q;
        out_dat_q  <= out_dat_d;
      end
    end
  end

  assign out_valid_o = out_vld_q;
  assign out_addr_o  = out_addr_q;
  assign out_data_o  = out_dat_q;
  assign finish_o    = finish_q;
  assign addr_err_o  = err_q;

endmodule

// File: tb/tb_blft_row_stream.sv
// Bench for blft_row_stream with a 4x2 frame: directed frames with random pixels,
// checked against an arithmetic reference model, including output timing,
// in_ready flush stalls, finish/restart, address-error flag and mid-frame reset.
module tb_blft_row_stream;
  localparam int DW = 9;
  localparam int AW = 16;
  localparam int IW = 4;
  localparam int NP = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic [DW-1:0] t_near;
  logic [DW-1:0] t_far;
  logic          bypass;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          finish;
  logic          addr_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference-model inputs for the frame under test.
  int pix[NP];
  int tn, tf;
  bit byp;

  int mon_addr[$];
  int mon_data[$];
  int mon_cyc[$];
  int xcyc[NP];
  int xwait[NP];

  blft_row_stream #(.DATA_W(DW), .ADDR_W(AW), .IMG_W(IW), .NUM_PIX(NP)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_addr_i  (in_addr),
    .in_data_i  (in_data),
    .t_near_i   (t_near),
    .t_far_i    (t_far),
    .bypass_i   (bypass),
    .out_valid_o(out_valid),
    .out_addr_o (out_addr),
    .out_data_o (out_data),
    .finish_o   (finish),
    .addr_err_o (addr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output strobe with the number of the edge that produced it.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      mon_addr.push_back(int'(out_addr));
      mon_data.push_back(int'(out_data));
      mon_cyc.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int wt(input int d);
    if (d <= tn) return 2;
    if (d <= tf) return 1;
    return 0;
  endfunction

  // Expected filtered value at raster address a, straight from the filter rules.
  function automatic int ref_out(input int a);
    int c, pl, pc, pr, wl, wr, w;
    c  = a % IW;
    pc = pix[a];
    pl = (c == 0) ? pc : pix[a-1];
    pr = (c == IW - 1) ? pc : pix[a+1];
    if (byp) return pc;
    wl = wt((pl > pc) ? pl - pc : pc - pl);
    wr = wt((pr > pc) ? pr - pc : pc - pr);
    w  = 4 + wl + wr;
    return (4 * pc + wl * pl + wr * pr + w / 2) / w;
  endfunction

  task automatic clear_mon();
    mon_addr.delete();
    mon_data.delete();
    mon_cyc.delete();
  endtask

  // Present one pixel at a negedge, wait (bounded) for in_ready, then idle for gap cycles.
  task automatic xfer_px(input int a, input int d, input int gap, output int waited, output int xc);
    in_valid = 1'b1;
    in_addr  = AW'(a);
    in_data  = DW'(d);
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    xc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input int gapmax, input bit restart);
    int gaps[NP];
    int fcyc, n, ew, ec, k;
    t_near = DW'(tn);
    t_far  = DW'(tf);
    bypass = byp;
    clear_mon();
    for (int a = 0; a < NP; a++) gaps[a] = (a == NP - 1) ? 0 : int'($urandom_range(0, gapmax));
    if (restart) chk({tag, "_finish_held"}, 32'(finish), 32'd1);
    for (int a = 0; a < NP; a++) begin
      xfer_px(a, pix[a], gaps[a], xwait[a], xcyc[a]);
      if (a == 0 && restart) chk({tag, "_finish_clr"}, 32'(finish), 32'd0);
    end
    for (int a = 0; a < NP; a++) begin
      ew = (a > 0 && (a % IW) == 0 && gaps[a-1] == 0) ? 1 : 0;
      chk($sformatf("%s_stall%0d", tag, a), 32'(xwait[a]), 32'(ew));
    end
    k = 0;
    while (finish !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    fcyc = cyc;
    chk({tag, "_finish_cyc"}, 32'(fcyc), 32'(xcyc[NP-1] + 4));
    n = mon_addr.size();
    chk({tag, "_count"}, 32'(n), 32'(NP));
    for (int i = 0; i < NP && i < n; i++) begin
      ec = ((i % IW) == IW - 1) ? xcyc[i] + 3 : xcyc[i+1] + 2;
      chk($sformatf("%s_addr%0d", tag, i), 32'(mon_addr[i]), 32'(i));
      chk($sformatf("%s_data%0d", tag, i), 32'(mon_data[i]), 32'(ref_out(i)));
      chk($sformatf("%s_cyc%0d", tag, i), 32'(mon_cyc[i]), 32'(ec));
    end
    chk({tag, "_addr_err"}, 32'(addr_err), 32'd0);
    chk({tag, "_ready_idle"}, 32'(in_ready), 32'd1);
  endtask

  task automatic rand_pix();
    int base;
    base = int'($urandom_range(0, 490));
    for (int i = 0; i < NP; i++) pix[i] = base + int'($urandom_range(0, 20));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_addr"}, 32'(out_addr), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_finish"}, 32'(finish), 32'd0);
    chk({tag, "_addr_err"}, 32'(addr_err), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int w, xc;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    t_near   = '0;
    t_far    = '0;
    bypass   = 1'b0;
    #2;
    reset_checks("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: directed first row, random second row
    tn = 2; tf = 5; byp = 0;
    pix[0] = 10; pix[1] = 11; pix[2] = 20; pix[3] = 21;
    for (int i = IW; i < NP; i++) pix[i] = int'($urandom_range(0, 511));
    run_frame("t1", 2, 0);
    chk("t1_px0", 32'(mon_data[0]), 32'd10);
    chk("t1_px1", 32'(mon_data[1]), 32'd11);
    chk("t1_px2", 32'(mon_data[2]), 32'd20);

    // 2: constant frame, random thresholds
    tn = int'($urandom_range(0, 511)); tf = int'($urandom_range(0, 511)); byp = 0;
    for (int i = 0; i < NP; i++) pix[i] = 100;
    run_frame("t2", 1, 1);
    for (int i = 0; i < mon_data.size(); i++) chk($sformatf("t2_const%0d", i), 32'(mon_data[i]), 32'd100);

    // 3: bypass with random data and random gaps
    tn = int'($urandom_range(0, 5)); tf = tn + int'($urandom_range(0, 8)); byp = 1;
    for (int i = 0; i < NP; i++) pix[i] = int'($urandom_range(0, 511));
    run_frame("t3", 3, 1);

    // 4: back-to-back input, clustered random data so all weights occur
    tn = int'($urandom_range(0, 4)); tf = tn + int'($urandom_range(1, 8)); byp = 0;
    rand_pix();
    run_frame("t4", 0, 1);

    // 5: address skip sets a sticky error; output addresses keep counting
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tn = 2; tf = 5; byp = 0;
    t_near = DW'(tn); t_far = DW'(tf); bypass = 1'b0;
    rand_pix();
    clear_mon();
    xfer_px(0, pix[0], 1, w, xc);
    xfer_px(1, pix[1], 1, w, xc);
    chk("t5_err_pre", 32'(addr_err), 32'd0);
    xfer_px(3, pix[2], 1, w, xc);
    chk("t5_err_set", 32'(addr_err), 32'd1);
    xfer_px(4, pix[3], 1, w, xc);
    repeat (6) @(negedge clk);
    chk("t5_err_hold", 32'(addr_err), 32'd1);
    chk("t5_count", 32'(mon_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < mon_addr.size(); i++) chk($sformatf("t5_addr%0d", i), 32'(mon_addr[i]), 32'(i));

    // 6: reset in the middle of row 1, then a fresh frame
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tn = int'($urandom_range(0, 4)); tf = tn + int'($urandom_range(0, 8)); byp = 0;
    t_near = DW'(tn); t_far = DW'(tf); bypass = 1'b0;
    rand_pix();
    for (int a = 0; a < 6; a++) xfer_px(a, pix[a], 0, w, xc);
    rst_n = 1'b0;
    #1;
    reset_checks("t6_rst");
    clear_mon();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_quiet", 32'(mon_addr.size()), 32'd0);
    rand_pix();
    run_frame("t6", 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
